mem_stage: RTL and testbench

- Pipeline MEM stage. Consumes the EX-stage outputs: result, mem_data, if_mem_read/if_mem_write, load_byte, if_reg_write, data_write_reg.
- Performs LW/LB/SW/SB against an asynchronous 32-bit SRAM via a multi-cycle strobe FSM, including read-modify-write for SB.
- Non-memory instructions pass through to WB with one register stage.
- Holds upstream with mem_busy while an access is in flight.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_byte_lane.sv | 42 ++++
 rtl/mem_stage.sv | 191 +++++++++++++++++++
 tb/tb_mem_stage.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM pipeline stage: FSM state encoding,
// byte-lane select codes and the byte sign-extension helper.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_RMW_RD   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [1:0] BYTE_SEL_0 = 2'b00;
  localparam logic [1:0] BYTE_SEL_1 = 2'b01;
  localparam logic [1:0] BYTE_SEL_2 = 2'b10;
  localparam logic [1:0] BYTE_SEL_3 = 2'b11;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Asynchronous SRAM bus between the MEM stage (master) and the memory
// device or its model (slave). Strobes are active-low.
interface mem_stage_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [31:0]       sram_wdata;
  logic              sram_wdata_oe;
  logic [31:0]       sram_rdata;

  modport master (
    output sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_wdata, sram_wdata_oe,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_wdata, sram_wdata_oe,
    output sram_rdata
  );
endinterface

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for the 32-bit SRAM word: extracts and sign-extends the
// addressed byte for LB, and merges a store byte into the word for SB.
// Little-endian: select 00 is bits [7:0], select 11 is bits [31:24].
module mem_byte_lane
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_word,
  input  logic [1:0]  byte_sel,
  input  logic [7:0]  store_byte,
  output logic [31:0] load_ext,
  output logic [31:0] merged_word
);

  // Pick the addressed lane for both the load extract and the store merge
  always_comb begin
    load_ext    = sext8(rdata_word[7:0]);
    merged_word = rdata_word;
    unique case (byte_sel)
      BYTE_SEL_0: begin
        load_ext          = sext8(rdata_word[7:0]);
        merged_word[7:0]  = store_byte;
      end
      BYTE_SEL_1: begin
        load_ext          = sext8(rdata_word[15:8]);
        merged_word[15:8] = store_byte;
      end
      BYTE_SEL_2: begin
        load_ext           = sext8(rdata_word[23:16]);
        merged_word[23:16] = store_byte;
      end
      BYTE_SEL_3: begin
        load_ext           = sext8(rdata_word[31:24]);
        merged_word[31:24] = store_byte;
      end
      default: begin
        load_ext    = sext8(rdata_word[7:0]);
        merged_word = rdata_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage. Runs LW/LB/SW/SB against an asynchronous SRAM through a
// multi-cycle strobe FSM (SB is a read-modify-write), passes non-memory
// instructions to WB through one register stage, and stalls upstream with
// mem_busy while an access is in flight.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_mem_read_i,
  input  logic        if_mem_write_i,
  input  logic        load_byte_i,
  input  logic [31:0] result_i,
  input  logic [31:0] mem_data_i,
  input  logic        if_reg_write_i,
  input  logic [4:0]  data_write_reg_i,
  output logic        mem_busy,
  output logic [31:0] wb_data_o,
  output logic        if_reg_write_o,
  output logic [4:0]  data_write_reg_o,
  mem_stage_if.master sram
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        byte_off_q;
  logic              byte_q;
  logic              reg_write_q;
  logic [4:0]        dst_q;
  logic [7:0]        store_byte_q;
  logic [31:0]       wdata_q;

  logic              ce_n_q, oe_n_q, we_n_q, wdata_oe_q;
  logic              ce_n_nxt, oe_n_nxt, we_n_nxt, wdata_oe_nxt;

  logic              accept;
  logic              last_read;
  logic              last_pulse;
  logic [31:0]       load_ext;
  logic [31:0]       merged_word;
  logic [31:0]       load_value;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^result_i[31:ADDR_W+2];

  assign accept     = (state == S_IDLE) && (if_mem_read_i || if_mem_write_i);
  assign last_read  = (cnt == RD_LAST);
  assign last_pulse = (cnt == PULSE_LAST);
  assign load_value = byte_q ? load_ext : sram.sram_rdata;

  assign sram.sram_addr     = addr_q;
  assign sram.sram_ce_n     = ce_n_q;
  assign sram.sram_oe_n     = oe_n_q;
  assign sram.sram_we_n     = we_n_q;
  assign sram.sram_wdata    = wdata_q;
  assign sram.sram_wdata_oe = wdata_oe_q;

  mem_byte_lane u_byte_lane (
    .rdata_word  (sram.sram_rdata),
    .byte_sel    (byte_off_q),
    .store_byte  (store_byte_q),
    .load_ext    (load_ext),
    .merged_word (merged_word)
  );

  // Next-state selection, upstream stall and the strobe levels for the next state
  always_comb begin
    next_state   = state;
    ce_n_nxt     = 1'b1;
    oe_n_nxt     = 1'b1;
    we_n_nxt     = 1'b1;
    wdata_oe_nxt = 1'b0;
    mem_busy     = ((state != S_IDLE) && (state != S_DONE)) || accept;

    unique case (state)
      S_IDLE: begin
        if (if_mem_write_i) begin
          next_state = load_byte_i ? S_RMW_RD : S_WR_SETUP;
        end else if (if_mem_read_i) begin
          next_state = S_RD;
        end
      end
      S_RD:       if (last_read)  next_state = S_DONE;
      S_RMW_RD:   if (last_read)  next_state = S_WR_SETUP;
      S_WR_SETUP: next_state = S_WR_PULSE;
      S_WR_PULSE: if (last_pulse) next_state = S_WR_HOLD;
      S_WR_HOLD:  next_state = S_DONE;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase

    unique case (next_state)
      S_RD, S_RMW_RD: begin
        ce_n_nxt = 1'b0;
        oe_n_nxt = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ce_n_nxt     = 1'b0;
        wdata_oe_nxt = 1'b1;
      end
      S_WR_PULSE: begin
        ce_n_nxt     = 1'b0;
        we_n_nxt     = 1'b0;
        wdata_oe_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // State register, per-state cycle counter and registered SRAM strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      wdata_oe_q <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= ((next_state != state) || (state == S_IDLE)) ? '0 : cnt + 1'b1;
      ce_n_q     <= ce_n_nxt;
      oe_n_q     <= oe_n_nxt;
      we_n_q     <= we_n_nxt;
      wdata_oe_q <= wdata_oe_nxt;
    end
  end

  // Request capture, write-data/merge register and the WB output register
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q           <= '0;
      byte_off_q       <= '0;
      byte_q           <= 1'b0;
      reg_write_q      <= 1'b0;
      dst_q            <= '0;
      store_byte_q     <= '0;
      wdata_q          <= '0;
      wb_data_o        <= '0;
      if_reg_write_o   <= 1'b0;
      data_write_reg_o <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q         <= result_i[ADDR_W+1:2];
            byte_off_q     <= result_i[1:0];
            byte_q         <= load_byte_i;
            reg_write_q    <= if_reg_write_i;
            dst_q          <= data_write_reg_i;
            store_byte_q   <= mem_data_i[7:0];
            if (if_mem_write_i && !load_byte_i) begin
              wdata_q <= mem_data_i;
            end
            if_reg_write_o <= 1'b0;
          end else begin
            wb_data_o        <= result_i;
            if_reg_write_o   <= if_reg_write_i;
            data_write_reg_o <= data_write_reg_i;
          end
        end
        S_RD: begin
          if (last_read) begin
            wb_data_o        <= load_value;
            if_reg_write_o   <= reg_write_q;
            data_write_reg_o <= dst_q;
          end
        end
        S_RMW_RD: begin
          if (last_read) begin
            wdata_q <= merged_word;
          end
        end
        S_DONE: begin
          if_reg_write_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of instructions driven through a scoreboard,
// behavioural async SRAM model, strobe-rule monitor, and hand-written
// reset sequences.
module tb_mem_stage;

  localparam int ADDR_W = 20;
  localparam int W      = 1;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic        bf;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic [4:0]  dst;
    logic [31:0] exp_wb;
    logic        exp_rw;
    int          exp_busy;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] wb;
    logic        rw;
    logic [4:0]  dst;
    logic        chk_wb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_mem_read_i, if_mem_write_i, load_byte_i, if_reg_write_i;
  logic [31:0] result_i, mem_data_i;
  logic [4:0]  data_write_reg_i;
  logic        mem_busy, if_reg_write_o;
  logic [31:0] wb_data_o;
  logic [4:0]  data_write_reg_o;

  int checks = 0;
  int failures = 0;
  int violations = 0;
  int we_low = 0;
  int oe_low = 0;

  logic [31:0] sram_mem [0:255];
  logic [31:0] exp_mem  [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  exp_t exp_q[$];
  vec_t vecs[14];

  mem_stage_if #(.ADDR_W(ADDR_W)) sram_bus ();

  mem_stage #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_mem_read_i    (if_mem_read_i),
    .if_mem_write_i   (if_mem_write_i),
    .load_byte_i      (load_byte_i),
    .result_i         (result_i),
    .mem_data_i       (mem_data_i),
    .if_reg_write_i   (if_reg_write_i),
    .data_write_reg_i (data_write_reg_i),
    .mem_busy         (mem_busy),
    .wb_data_o        (wb_data_o),
    .if_reg_write_o   (if_reg_write_o),
    .data_write_reg_o (data_write_reg_o),
    .sram             (sram_bus.slave)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: combinational read while ce/oe low, write while ce/we low
  assign sram_bus.sram_rdata = (!sram_bus.sram_ce_n && !sram_bus.sram_oe_n)
                               ? sram_mem[sram_bus.sram_addr[7:0]] : 32'h0BAD_0BAD;

  always @(posedge clk) begin
    if (pl_en) begin
      sram_mem[pl_addr] <= pl_data;
    end else if (!sram_bus.sram_ce_n && !sram_bus.sram_we_n && sram_bus.sram_wdata_oe) begin
      sram_mem[sram_bus.sram_addr[7:0]] <= sram_bus.sram_wdata;
    end
  end

  // Strobe-rule monitor and per-access strobe cycle counters
  always @(negedge clk) begin
    if (!sram_bus.sram_we_n && !sram_bus.sram_oe_n) violations++;
    if (sram_bus.sram_wdata_oe && !sram_bus.sram_oe_n) violations++;
    if (!sram_bus.sram_we_n) we_low++;
    if (!sram_bus.sram_oe_n) oe_low++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rd, input logic wr, input logic bf,
                              input logic [31:0] addr, input logic [31:0] data, input logic rw,
                              input logic [4:0] dst, input logic [31:0] exp_wb, input logic exp_rw,
                              input int exp_busy);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.bf = bf; v.addr = addr; v.data = data;
    v.rw = rw; v.dst = dst; v.exp_wb = exp_wb; v.exp_rw = exp_rw; v.exp_busy = exp_busy;
    return v;
  endfunction

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic drive_idle();
    if_mem_read_i = 1'b0; if_mem_write_i = 1'b0; load_byte_i = 1'b0;
    result_i = '0; mem_data_i = '0; if_reg_write_i = 1'b0; data_write_reg_i = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   busy_n;
    bit   first;
    logic [7:0] idx;
    int   off;
    bit   is_mem;
    bit   is_store;

    is_mem   = v.rd || v.wr;
    is_store = v.wr;
    idx      = v.addr[9:2];
    off      = int'(v.addr[1:0]);
    if (is_store) begin
      if (v.bf)
        exp_mem[idx] = (exp_mem[idx] & ~(32'hFF << (8 * off))) | ({24'h0, v.data[7:0]} << (8 * off));
      else
        exp_mem[idx] = v.data;
    end

    @(negedge clk);
    if_mem_read_i = v.rd; if_mem_write_i = v.wr; load_byte_i = v.bf;
    result_i = v.addr; mem_data_i = v.data; if_reg_write_i = v.rw; data_write_reg_i = v.dst;
    we_low = 0; oe_low = 0;
    e.name = v.name; e.wb = v.exp_wb; e.rw = v.exp_rw; e.dst = v.dst; e.chk_wb = !is_store;
    exp_q.push_back(e);
    #1;

    busy_n = 0;
    first  = 1'b1;
    while (mem_busy && busy_n < 40) begin
      busy_n++;
      @(posedge clk); #1;
      if (first && is_mem) begin
        chk({v.name, "_accept_rw_off"}, 32'(if_reg_write_o), 32'h0);
        chk({v.name, "_sram_addr"}, 32'(sram_bus.sram_addr), 32'(v.addr[ADDR_W+1:2]));
        first = 1'b0;
      end
    end
    if (busy_n == 0) begin
      @(posedge clk); #1;
    end
    chk({v.name, "_busy_cycles"}, 32'(busy_n), 32'(v.exp_busy));

    if (is_mem) begin
      chk({v.name, "_we_low_cycles"}, 32'(we_low), is_store ? 32'(W) : 32'h0);
      chk({v.name, "_oe_low_cycles"}, 32'(oe_low), (!is_store || v.bf) ? 32'(W + 1) : 32'h0);
    end
    if (is_store) begin
      chk({v.name, "_mem_word"}, sram_mem[idx], exp_mem[idx]);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      chk({e.name, "_rw"}, 32'(if_reg_write_o), 32'(e.rw));
      if (e.chk_wb) begin
        chk({e.name, "_wb"}, wb_data_o, e.wb);
        chk({e.name, "_dst"}, 32'(data_write_reg_o), 32'(e.dst));
      end
    end
  endtask

  initial begin
    vecs[0]  = mk("alu",      1'b0, 1'b0, 1'b0, 32'h0000_0005, 32'h0,          1'b1, 5'd3,  32'h0000_0005, 1'b1, 0);
    vecs[1]  = mk("lw_b2b",   1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,          1'b1, 5'd7,  32'hDEAD_BEEF, 1'b1, W + 2);
    vecs[2]  = mk("lb_off0",  1'b1, 1'b0, 1'b1, 32'h0000_0014, 32'h0,          1'b1, 5'd8,  32'h0000_0001, 1'b1, W + 2);
    vecs[3]  = mk("lb_off1",  1'b1, 1'b0, 1'b1, 32'h0000_0015, 32'h0,          1'b1, 5'd9,  32'h0000_007F, 1'b1, W + 2);
    vecs[4]  = mk("lb_off2",  1'b1, 1'b0, 1'b1, 32'h0000_0016, 32'h0,          1'b1, 5'd10, 32'hFFFF_FFFF, 1'b1, W + 2);
    vecs[5]  = mk("lb_off3",  1'b1, 1'b0, 1'b1, 32'h0000_0017, 32'h0,          1'b1, 5'd11, 32'hFFFF_FF80, 1'b1, W + 2);
    vecs[6]  = mk("sw",       1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678,  1'b1, 5'd4,  32'h0,         1'b0, W + 3);
    vecs[7]  = mk("sw_prime", 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h1122_3344,  1'b0, 5'd0,  32'h0,         1'b0, W + 3);
    vecs[8]  = mk("sb",       1'b0, 1'b1, 1'b1, 32'h0000_0022, 32'hFFFF_FFAB,  1'b1, 5'd5,  32'h0,         1'b0, 2 * W + 4);
    vecs[9]  = mk("lw_sb",    1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0,          1'b1, 5'd12, 32'h11AB_3344, 1'b1, W + 2);
    vecs[10] = mk("rdwr",     1'b1, 1'b1, 1'b0, 32'h0000_0024, 32'hCAFE_F00D,  1'b1, 5'd13, 32'h0,         1'b0, W + 3);
    vecs[11] = mk("lw_rdwr",  1'b1, 1'b0, 1'b0, 32'h0000_0024, 32'h0,          1'b0, 5'd14, 32'hCAFE_F00D, 1'b0, W + 2);
    vecs[12] = mk("alu_nowb", 1'b0, 1'b0, 1'b0, 32'hA5A5_0000, 32'h0,          1'b0, 5'd31, 32'hA5A5_0000, 1'b0, 0);
    vecs[13] = mk("lb_hi",    1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'h0,          1'b1, 5'd1,  32'hFFFF_FFDE, 1'b1, W + 2);

    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n",     32'(sram_bus.sram_ce_n), 32'h1);
    chk("rst_oe_n",     32'(sram_bus.sram_oe_n), 32'h1);
    chk("rst_we_n",     32'(sram_bus.sram_we_n), 32'h1);
    chk("rst_wdata_oe", 32'(sram_bus.sram_wdata_oe), 32'h0);
    chk("rst_wb",       wb_data_o, 32'h0);
    chk("rst_rw",       32'(if_reg_write_o), 32'h0);
    chk("rst_dst",      32'(data_write_reg_o), 32'h0);
    chk("rst_addr",     32'(sram_bus.sram_addr), 32'h0);
    chk("rst_wdata",    sram_bus.sram_wdata, 32'h0);
    chk("rst_busy",     32'(mem_busy), 32'h0);

    preload(8'd4, 32'hDEAD_BEEF);
    preload(8'd5, 32'h80FF_7F01);
    preload(8'd8, 32'h0000_0000);
    preload(8'd9, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
      if (vecs[i].rd || vecs[i].wr) begin
        @(negedge clk);
        drive_idle();
      end
    end

    @(negedge clk);
    if_mem_write_i = 1'b1; load_byte_i = 1'b0; result_i = 32'h0000_0030;
    mem_data_i = 32'h0000_0055; if_reg_write_i = 1'b0; data_write_reg_i = 5'd0;
    @(posedge clk); #1;
    chk("wr_setup_ce_n",     32'(sram_bus.sram_ce_n), 32'h0);
    chk("wr_setup_we_n",     32'(sram_bus.sram_we_n), 32'h1);
    chk("wr_setup_wdata_oe", 32'(sram_bus.sram_wdata_oe), 32'h1);
    @(posedge clk); #1;
    chk("wr_pulse_we_n",     32'(sram_bus.sram_we_n), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    chk("midrst_we_n",     32'(sram_bus.sram_we_n), 32'h1);
    chk("midrst_ce_n",     32'(sram_bus.sram_ce_n), 32'h1);
    chk("midrst_wdata_oe", 32'(sram_bus.sram_wdata_oe), 32'h0);
    chk("midrst_busy",     32'(mem_busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mk("alu_after_rst", 1'b0, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 1'b1, 5'd2,
                     32'h0000_0077, 1'b1, 0));
    checkOutput();

    chk("strobe_rules", 32'(violations), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
